hamming_link_ctrl: RTL

Sequencing controller for the Hamming(7,4) datapath. Accepts 4-bit data words over a valid/ready handshake and encodes each one with an encoder instance. It applies an optional per-word error-injection mask to model a noisy channel, then computes the syndrome with a syndrome instance. It corrects any single-bit error and presents the decoded word on an output valid/ready handshake, together with status and an error counter. It sits between a data source and sink as the loopback and test harness for the code.

---
 rtl/hamming_link_ctrl.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/hamming_link_ctrl.sv
// -----------------------------------------------------------------------------
// hamming_link_ctrl
//   Loopback sequencing controller for a Hamming(7,4) code. The block accepts
//   one 4-bit word at a time and encodes it. It XORs an error-injection mask
//   into the codeword and computes the syndrome. It then corrects a single-bit
//   error and presents the decoded word together with status.
//
//   Codeword layout (Hamming position p lives in bit p-1):
//     code[0]=p1 code[1]=p2 code[2]=d0 code[3]=p4
//     code[4]=d1 code[5]=d2 code[6]=d3
//
//   Optional build macro: HAM_SINGLE_STEP_EN
//     When defined, a 'step' input is added. The ENC->CHK and CHK->OUT
//     transitions then advance only on cycles where step=1.
//
// Ports (hamming_link_ctrl):
//   clk, rst             rising-edge clock, synchronous active-high reset
//   in_valid/in_ready    input handshake; ready only while idle
//   data_in[3:0]         data nibble to encode
//   err_mask[6:0]        bits XORed into the codeword
//   out_valid/out_ready  output handshake
//   data_out[3:0]        corrected data nibble
//   code_rx[6:0]         received (possibly corrupted) codeword
//   syn_out[2:0]         syndrome of code_rx
//   corrected            syndrome was nonzero for this word
//   err_count[CNT_W-1:0] saturating count of words with nonzero syndrome
//   step                 (HAM_SINGLE_STEP_EN only) single-step advance
// -----------------------------------------------------------------------------

// Hamming(7,4) encoder: data nibble -> 7-bit codeword.
module hamming74_enc (
  input  logic [3:0] data,
  output logic [6:0] code
);
  function automatic logic [6:0] ham_encode(input logic [3:0] d);
    logic p1_s, p2_s, p4_s;
    p1_s = d[0] ^ d[1] ^ d[3];
    p2_s = d[0] ^ d[2] ^ d[3];
    p4_s = d[1] ^ d[2] ^ d[3];
    return {d[3], d[2], d[1], p4_s, d[0], p2_s, p1_s};
  endfunction

  assign code = ham_encode(data);
endmodule

// Hamming(7,4) syndrome: value is the position (1..7) of a single flipped bit.
module hamming74_syn (
  input  logic [6:0] code,
  output logic [2:0] syn
);
  function automatic logic [2:0] ham_syndrome(input logic [6:0] c);
    logic s1_s, s2_s, s4_s;
    s1_s = c[0] ^ c[2] ^ c[4] ^ c[6];
    s2_s = c[1] ^ c[2] ^ c[5] ^ c[6];
    s4_s = c[3] ^ c[4] ^ c[5] ^ c[6];
    return {s4_s, s2_s, s1_s};
  endfunction

  assign syn = ham_syndrome(code);
endmodule

module hamming_link_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
`ifdef HAM_SINGLE_STEP_EN
  input  logic             step,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       data_in,
  input  logic [6:0]       err_mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       data_out,
  output logic [6:0]       code_rx,
  output logic [2:0]       syn_out,
  output logic             corrected,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ENC  = 2'd1,
    CHK  = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t           state_r, state_s;
  logic [3:0]       data_r;
  logic [6:0]       mask_r;
  logic [6:0]       code_rx_r;
  logic [2:0]       syn_r;
  logic [3:0]       data_out_r;
  logic             corrected_r;
  logic [CNT_W-1:0] err_count_r;

  logic [6:0]       enc_code_s;
  logic [2:0]       syn_s;
  logic [6:0]       fixed_s;
  logic             advance_s;

  hamming74_enc u_enc (.data(data_r),    .code(enc_code_s));
  hamming74_syn u_syn (.code(code_rx_r), .syn(syn_s));

`ifdef HAM_SINGLE_STEP_EN
  assign advance_s = step;
`else
  assign advance_s = 1'b1;
`endif

  // Single-bit correction of the received word at the position named by the syndrome.
  always_comb begin
    fixed_s = code_rx_r;
    if (syn_s != 3'd0) begin
      fixed_s = code_rx_r ^ (7'd1 << (syn_s - 3'd1));
    end else begin
      fixed_s = code_rx_r;
    end
  end

  // Next-state logic of the one-word-in-flight sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) state_s = ENC;
        else          state_s = IDLE;
      end
      ENC: begin
        if (advance_s) state_s = CHK;
        else           state_s = ENC;
      end
      CHK: begin
        if (advance_s) state_s = OUT;
        else           state_s = CHK;
      end
      OUT: begin
        if (out_ready) state_s = IDLE;
        else           state_s = OUT;
      end
      default: state_s = IDLE;
    endcase
  end

  // State register plus datapath registers; results are frozen outside ENC/CHK.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      data_r      <= 4'd0;
      mask_r      <= 7'd0;
      code_rx_r   <= 7'd0;
      syn_r       <= 3'd0;
      data_out_r  <= 4'd0;
      corrected_r <= 1'b0;
      err_count_r <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_s;
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            data_r <= data_in;
            mask_r <= err_mask;
          end
        end
        ENC: begin
          code_rx_r <= enc_code_s ^ mask_r;
        end
        CHK: begin
          if (advance_s) begin
            syn_r       <= syn_s;
            data_out_r  <= {fixed_s[6], fixed_s[5], fixed_s[4], fixed_s[2]};
            corrected_r <= (syn_s != 3'd0);
            // Counter saturates at all-ones rather than wrapping.
            if ((syn_s != 3'd0) && (err_count_r != {CNT_W{1'b1}})) begin
              err_count_r <= err_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
          end
        end
        OUT: begin
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == OUT);
  assign data_out  = data_out_r;
  assign code_rx   = code_rx_r;
  assign syn_out   = syn_r;
  assign corrected = corrected_r;
  assign err_count = err_count_r;

endmodule
